serial_pair_serializer_msb_first: RTL and testbench
===================================================

Name: serial_pair_serializer_msb_first

Overview:
- Upstream feeder for the MSB-first serial comparator.
- Accepts a pair of WIDTH-bit words over a valid/ready handshake.
- Issues a one-cycle clear to the downstream comparator, then shifts both words out bit-serially, MSB first, one bit pair per accepted beat.
- Marks the first and last beats so the consumer knows when to sample the comparison result.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset, synchronous, active-low.
- in_valid, input, 1, word pair offered.
- in_ready, output, 1, block can accept a pair this cycle.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- cmp_clr, output, 1, one-cycle clear to the downstream comparator (drives its active-high rst).
- ser_valid, output, 1, ser_a/ser_b carry a live bit.
- ser_ready, input, 1, downstream accepts the current beat; tie to 1 for the comparator.
- ser_a, output, 1, current bit of A.
- ser_b, output, 1, current bit of B.
- ser_first, output, 1, current beat is the MSB.
- ser_last, output, 1, current beat is the LSB.

Behaviour:
- Reset:
  - While rst_n=0 at a clk edge: state <= ST_IDLE; shift registers and bit counter cleared.
  - in_ready is forced 0 while rst_n=0.
  - cmp_clr, ser_valid, ser_a, ser_b, ser_first and ser_last read 0 after the reset edge.
- States: ST_IDLE, ST_CLEAR, ST_SHIFT.
- ST_IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture in_a/in_b into shift registers, bit counter <= WIDTH-1, go to ST_CLEAR.
- ST_CLEAR: exactly one cycle. cmp_clr=1, ser_valid=0, in_ready=0. Always goes to ST_SHIFT.
- ST_SHIFT:
  - ser_valid=1, in_ready=0.
  - ser_a/ser_b are the MSBs of the shift registers.
  - ser_first=1 when counter==WIDTH-1; ser_last=1 when counter==0. Both are 1 when WIDTH=1.
- Beat advance:
  - Only on ser_valid & ser_ready: shift left by 1, counter decrements.
  - On the beat where ser_last is accepted, go to ST_IDLE.
- Stall (ser_ready=0): ser_a, ser_b, ser_first, ser_last and the counter hold. Repeated presentation of the same bit pair is harmless to an MSB-first comparator.
- Idle output gating: whenever ser_valid=0, ser_a=ser_b=0. The comparator sees an equal pair and its state does not change.
- Latency: the first data beat appears 2 cycles after the accept edge. With ser_ready=1, one word occupies WIDTH+1 cycles after the accept; the next word is accepted in the cycle after the last beat.
- Throughput: one pair per WIDTH+2 cycles at best; no overlap (in_ready=0 during ST_CLEAR and ST_SHIFT).
- Result sampling: the consumer samples the comparator flags on the cycle where ser_valid & ser_ready & ser_last.
- Reset mid-word: the word is discarded with no clear pulse and no further beats. After release the block is in ST_IDLE.
- in_a/in_b are don't-care except at the accept edge.
- The counter is $clog2(WIDTH) bits wide, with a minimum of 1. It never wraps because the state leaves ST_SHIFT at zero.

Decomposition:
- Shared package serial_cmp_pkg holds the state enum typedef (ST_IDLE, ST_CLEAR, ST_SHIFT) and a counter-width localparam function. The comparator FSM blocks reuse it.
- One natural sub-module: serial_word_shifter_msb_first. It is a parallel-load, enable-shift register instantiated twice (A and B). The FSM and counter stay in the top.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, ser_valid=0, cmp_clr=0 throughout; in_ready=1 in the first cycle after release.
2. WIDTH=4, in_a=4'b1010, in_b=4'b1001, ser_ready=1 -> cmp_clr=1 on the cycle after accept. The next 4 cycles give ser_a=1,0,1,0 and ser_b=1,0,0,1, with ser_first on beat 0 and ser_last on beat 3. The attached comparator shows a_greater_b=1 at the last beat.
3. Stall: same words, ser_ready=0 for 3 cycles at beat 1 -> beat 1 bits held, ser_first=ser_last=0 while held, last beat 3 cycles later than scenario 2.
4. Back-to-back: in_valid held with 4'b0110/4'b0110, then 4'b0011/4'b0100 -> second pair accepted in the cycle after the first ser_last; in_ready=0 during ST_CLEAR and ST_SHIFT. Comparator gives a_eq_b=1, then a_less_b=1.
5. Reset mid-word: rst_n=0 for 1 cycle at beat 2 -> ser_valid=0 on the next cycle and no cmp_clr. A new word 4'b1111/4'b0000 is then fully serialized with its own cmp_clr and ends with a_greater_b=1.
6. WIDTH=1 instance: in_a=0, in_b=1 -> one cmp_clr cycle, then a single beat with ser_first=ser_last=1, a_less_b=1, and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the MSB-first serial compare path: FSM state encoding
// and the bit-counter width helper.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // A 1-bit word still needs a 1-bit counter so the zero test is well formed.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_word_shifter_msb_first.sv
// Parallel-load, enable-shift register presenting its MSB; zeros fill from the LSB side.
module serial_word_shifter_msb_first #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] word_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= din;
    end else if (shift) begin
      word_q <= word_q << 1;
    end
  end

  assign msb = word_q[WIDTH-1];

endmodule

// File: rtl/serial_pair_serializer_msb_first.sv
// Accepts an A/B word pair, pulses a clear to the downstream comparator, then
// shifts both words out MSB first with first/last beat markers.
module serial_pair_serializer_msb_first
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             cmp_clr,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_first,
  output logic             ser_last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the offering side holds its payload stable until that edge.
  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          beat;
  logic          msb_a;
  logic          msb_b;

  assign in_ready  = rst_n && (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign cmp_clr   = (state == ST_CLEAR);
  assign ser_valid = (state == ST_SHIFT);
  assign beat      = ser_valid && ser_ready;

  // Gated to 0 outside ST_SHIFT so an attached comparator sees an equal pair.
  assign ser_a     = ser_valid && msb_a;
  assign ser_b     = ser_valid && msb_b;
  assign ser_first = ser_valid && (cnt == CNT_TOP);
  assign ser_last  = ser_valid && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_CLEAR;
            cnt   <= CNT_TOP;
          end
        end
        ST_CLEAR: state <= ST_SHIFT;
        ST_SHIFT: begin
          if (beat) begin
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  serial_word_shifter_msb_first #(.WIDTH(WIDTH)) u_shift_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (beat),
    .din   (in_a),
    .msb   (msb_a)
  );

  serial_word_shifter_msb_first #(.WIDTH(WIDTH)) u_shift_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (beat),
    .din   (in_b),
    .msb   (msb_b)
  );

endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// Bench for the pair serializer: a WIDTH=4 and a WIDTH=1 instance checked
// cycle by cycle against a queue of expected beats built from accepted words.
module tb_serial_pair_serializer_msb_first;

  logic clk;
  logic rst_n;

  logic       in_valid4, in_ready4, cmp_clr4, ser_valid4, ser_ready4;
  logic       ser_a4, ser_b4, ser_first4, ser_last4;
  logic [3:0] in_a4, in_b4;

  logic       in_valid1, in_ready1, cmp_clr1, ser_valid1, ser_ready1;
  logic       ser_a1, ser_b1, ser_first1, ser_last1;
  logic [0:0] in_a1, in_b1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_pair_serializer_msb_first #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .cmp_clr(cmp_clr4), .ser_valid(ser_valid4),
    .ser_ready(ser_ready4), .ser_a(ser_a4), .ser_b(ser_b4),
    .ser_first(ser_first4), .ser_last(ser_last4)
  );

  serial_pair_serializer_msb_first #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .cmp_clr(cmp_clr1), .ser_valid(ser_valid1),
    .ser_ready(ser_ready1), .ser_a(ser_a1), .ser_b(ser_b1),
    .ser_first(ser_first1), .ser_last(ser_last1)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 2 = a>b, 1 = a<b, 0 = equal
  function automatic logic [7:0] relation(input int a, input int b);
    return (a > b) ? 8'd2 : ((a < b) ? 8'd1 : 8'd0);
  endfunction

  // ---------------- scoreboard / reference model ----------------
  // Beat entry: {a_bit, b_bit, first, last}; word entry: {a, b}.
  logic [3:0] beat_q4[$];
  logic [7:0] word_q4[$];
  logic [3:0] beat_q1[$];
  logic [1:0] word_q1[$];
  logic       clr_due4 = 1'b0;
  logic       clr_due1 = 1'b0;
  logic [3:0] obs_a4, obs_b4;
  logic [3:0] bt4, bt1;
  logic [7:0] w4;
  logic [1:0] w1;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready4", {7'd0, in_ready4}, 8'd0);
      beat_q4.delete(); word_q4.delete(); clr_due4 = 1'b0;
      obs_a4 = '0; obs_b4 = '0;
    end else if (clr_due4) begin
      check("clr4_cmp_clr", {7'd0, cmp_clr4}, 8'd1);
      check("clr4_ser_valid", {7'd0, ser_valid4}, 8'd0);
      check("clr4_in_ready", {7'd0, in_ready4}, 8'd0);
      check("clr4_ser_ab", {6'd0, ser_a4, ser_b4}, 8'd0);
      clr_due4 = 1'b0;
    end else if (beat_q4.size() > 0) begin
      bt4 = beat_q4[0];
      check("beat4_valid", {7'd0, ser_valid4}, 8'd1);
      check("beat4_bits", {4'd0, ser_a4, ser_b4, ser_first4, ser_last4}, {4'd0, bt4});
      check("beat4_in_ready", {7'd0, in_ready4}, 8'd0);
      check("beat4_cmp_clr", {7'd0, cmp_clr4}, 8'd0);
      if (ser_ready4) begin
        obs_a4 = {obs_a4[2:0], ser_a4};
        obs_b4 = {obs_b4[2:0], ser_b4};
        void'(beat_q4.pop_front());
        if (bt4[0]) begin
          w4 = word_q4.pop_front();
          check("rel4", relation(int'(obs_a4), int'(obs_b4)),
                relation(int'(w4[7:4]), int'(w4[3:0])));
        end
      end
    end else begin
      check("idle4_in_ready", {7'd0, in_ready4}, 8'd1);
      check("idle4_outs", {3'd0, cmp_clr4, ser_valid4, ser_a4, ser_b4, ser_first4 | ser_last4}, 8'd0);
      if (in_valid4) begin
        clr_due4 = 1'b1;
        word_q4.push_back({in_a4, in_b4});
        for (int i = 3; i >= 0; i--)
          beat_q4.push_back({in_a4[i], in_b4[i], i == 3, i == 0});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready1", {7'd0, in_ready1}, 8'd0);
      beat_q1.delete(); word_q1.delete(); clr_due1 = 1'b0;
    end else if (clr_due1) begin
      check("clr1_cmp_clr", {7'd0, cmp_clr1}, 8'd1);
      check("clr1_ser_valid", {7'd0, ser_valid1}, 8'd0);
      check("clr1_in_ready", {7'd0, in_ready1}, 8'd0);
      clr_due1 = 1'b0;
    end else if (beat_q1.size() > 0) begin
      bt1 = beat_q1[0];
      check("beat1_valid", {7'd0, ser_valid1}, 8'd1);
      check("beat1_bits", {4'd0, ser_a1, ser_b1, ser_first1, ser_last1}, {4'd0, bt1});
      check("beat1_in_ready", {7'd0, in_ready1}, 8'd0);
      if (ser_ready1) begin
        void'(beat_q1.pop_front());
        w1 = word_q1.pop_front();
        check("rel1", relation(int'(ser_a1), int'(ser_b1)), relation(int'(w1[1]), int'(w1[0])));
      end
    end else begin
      check("idle1_in_ready", {7'd0, in_ready1}, 8'd1);
      check("idle1_outs", {3'd0, cmp_clr1, ser_valid1, ser_a1, ser_b1, ser_first1 | ser_last1}, 8'd0);
      if (in_valid1) begin
        clr_due1 = 1'b1;
        word_q1.push_back({in_a1, in_b1});
        beat_q1.push_back({in_a1[0], in_b1[0], 1'b1, 1'b1});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b);
    logic acc;
    acc = 1'b0;
    in_valid4 = 1'b1; in_a4 = a; in_b4 = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = in_ready4;
      cyc();
    end
    if (!acc) check("send4_timeout", 8'd1, 8'd0);
    in_valid4 = 1'b0;
  endtask

  task automatic send1(input logic a, input logic b);
    logic acc;
    acc = 1'b0;
    in_valid1 = 1'b1; in_a1 = a; in_b1 = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = in_ready1;
      cyc();
    end
    if (!acc) check("send1_timeout", 8'd1, 8'd0);
    in_valid1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid4 = 1'b0; in_valid1 = 1'b0;
    ser_ready4 = 1'b1; ser_ready1 = 1'b1;
    while ((beat_q4.size() > 0 || clr_due4 || beat_q1.size() > 0 || clr_due1) && n < 200) begin
      cyc(); n++;
    end
    if (n >= 200) check("drain_timeout", 8'd1, 8'd0);
    cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b1; in_a4 = 4'hF; in_b4 = 4'h0; ser_ready4 = 1'b1;
    in_valid1 = 1'b1; in_a1 = 1'b1; in_b1 = 1'b0; ser_ready1 = 1'b1;
    #1;
    repeat (3) cyc();
    in_valid4 = 1'b0; in_valid1 = 1'b0;
    rst_n = 1'b1;
    cyc();

    // basic word, then the same word with a 3-cycle stall on beat 1
    send4(4'b1010, 4'b1001);
    drain();
    send4(4'b1010, 4'b1001);
    cyc(); cyc();
    ser_ready4 = 1'b0;
    repeat (3) cyc();
    ser_ready4 = 1'b1;
    drain();

    // back-to-back with in_valid held
    send4(4'b0110, 4'b0110);
    send4(4'b0011, 4'b0100);
    drain();

    // reset during beat 2, then a fresh word
    send4(4'b1100, 4'b0011);
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    send4(4'b1111, 4'b0000);
    drain();

    // single-bit instance
    send1(1'b0, 1'b1);
    drain();
    send1(1'b1, 1'b0);
    drain();

    // random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      in_valid4  = 1'($urandom_range(0, 1));
      in_a4      = 4'($urandom_range(0, 15));
      in_b4      = 4'($urandom_range(0, 15));
      ser_ready4 = ($urandom_range(0, 3) != 0);
      in_valid1  = 1'($urandom_range(0, 1));
      in_a1      = 1'($urandom_range(0, 1));
      in_b1      = 1'($urandom_range(0, 1));
      ser_ready1 = ($urandom_range(0, 2) != 0);
      rst_n      = ($urandom_range(0, 99) != 0);
      cyc();
    end
    rst_n = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
